// File: rtl/seq_mult_unit_if.sv
// Operand/result bundle between the EX-stage control and the iterative multiplier.
// master drives the request side; slave is the multiplier itself.
interface seq_mult_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_mult;
    logic             mult_sign;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start_mult, mult_sign, src_a, src_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start_mult, mult_sign, src_a, src_b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/seq_mult_unit.sv
// Radix-2 shift-add MULT/MULTU unit: done and HI/LO appear WIDTH+1 cycles after accept.
// No backpressure: starts are taken only in IDLE (including the done cycle), otherwise ignored.
module seq_mult_unit #(
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            reset,
    seq_mult_unit_if.slave mif
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic               neg_flag;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] result;

    // Magnitude of -2^(W-1) wraps to 2^(W-1), which is exactly right as an unsigned value.
    always_comb begin
        abs_a   = (mif.mult_sign && mif.src_a[WIDTH-1]) ? (~mif.src_a + 1'b1) : mif.src_a;
        abs_b   = (mif.mult_sign && mif.src_b[WIDTH-1]) ? (~mif.src_b + 1'b1) : mif.src_b;
        sum     = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        product = {acc_hi, acc_lo};
        result  = neg_flag ? (~product + 1'b1) : product;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            neg_flag <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mif.start_mult) begin
                        mcand    <= abs_a;
                        mplier   <= abs_b;
                        neg_flag <= mif.mult_sign & (mif.src_a[WIDTH-1] ^ mif.src_b[WIDTH-1]);
                        acc_hi   <= '0;
                        acc_lo   <= '0;
                        cnt      <= CW'(WIDTH - 1);
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Carry bit of the add lands in acc_hi MSB as the pair shifts right.
                    acc_hi <= sum[WIDTH:1];
                    acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    hi_q   <= result[2*WIDTH-1:WIDTH];
                    lo_q   <= result[WIDTH-1:0];
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mif.busy = (state != S_IDLE);
    assign mif.done = done_q;
    assign mif.hi   = hi_q;
    assign mif.lo   = lo_q;
endmodule
